// File: rtl/shift_job_sequencer.sv
// Multi-cycle job controller for a shared 4-bit barrel shifter: arbitrates two
// requesters round-robin and splits each job into passes of at most 3 positions.
module shift_job_sequencer #(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [3:0]       req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_dir,
    input  logic             req0_rotate,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_dir,
    input  logic             req1_rotate,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic [3:0]       resp_data,
    output logic             resp_id,
    input  logic             resp_ready,
    output logic             busy,
    output logic [3:0]       shf_data_in,
    output logic [1:0]       shf_amt,
    output logic             shf_dir,
    output logic             shf_rotate,
    input  logic [3:0]       shf_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             rr_ptr_r;
    logic [3:0]       work_r;
    logic [AMT_W-1:0] remaining_r;
    logic             dir_r;
    logic             rotate_r;
    logic             id_r;

    logic             any_valid_s;
    logic             grant_s;
    logic             accept_s;
    logic [1:0]       chunk_s;
    logic [AMT_W-1:0] rem_nxt_s;

    // Arbitration: a lone requester wins outright, contention resolved by rr_ptr_r
    always_comb begin
        any_valid_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_s = rr_ptr_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        accept_s = (state_r == ST_IDLE) && any_valid_s;
    end

    // Per-pass chunk is the remaining amount clipped to the shifter's 0..3 range
    always_comb begin
        if (remaining_r > AMT_W'(3)) begin
            chunk_s = 2'd3;
        end else begin
            chunk_s = remaining_r[1:0];
        end
        rem_nxt_s = remaining_r - {{(AMT_W-2){1'b0}}, chunk_s};
    end

    // Next-state logic; a zero-amount job still makes one pass before DONE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (rem_nxt_s == '0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, job latch on accept and per-pass work/remaining update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= 1'b0;
            work_r      <= 4'd0;
            remaining_r <= '0;
            dir_r       <= 1'b0;
            rotate_r    <= 1'b0;
            id_r        <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                work_r      <= grant_s ? req1_data   : req0_data;
                remaining_r <= grant_s ? req1_amt    : req0_amt;
                dir_r       <= grant_s ? req1_dir    : req0_dir;
                rotate_r    <= grant_s ? req1_rotate : req0_rotate;
                id_r        <= grant_s;
                rr_ptr_r    <= ~grant_s;
            end else if (state_r == ST_SHIFT) begin
                work_r      <= shf_data_out;
                remaining_r <= rem_nxt_s;
            end
        end
    end

    assign req0_ready  = accept_s & ~grant_s;
    assign req1_ready  = accept_s &  grant_s;
    assign resp_valid  = (state_r == ST_DONE);
    assign resp_data   = (state_r == ST_DONE) ? work_r : 4'd0;
    assign resp_id     = (state_r == ST_DONE) ? id_r : 1'b0;
    assign busy        = (state_r == ST_SHIFT) || (state_r == ST_DONE);
    assign shf_data_in = work_r;
    assign shf_amt     = (state_r == ST_SHIFT) ? chunk_s : 2'd0;
    assign shf_dir     = dir_r;
    assign shf_rotate  = rotate_r;

endmodule

// File: tb/tb_shift_job_sequencer.sv
// Randomized self-checking bench for shift_job_sequencer; the external barrel
// shifter is modelled here and results are compared with a closed-form model.
module tb_shift_job_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_data, req1_data;
    logic [3:0] req0_amt, req1_amt;
    logic       req0_dir, req1_dir, req0_rotate, req1_rotate;
    logic       req0_ready, req1_ready;
    logic       resp_valid, resp_id, resp_ready, busy;
    logic [3:0] resp_data, shf_data_in, shf_data_out;
    logic [1:0] shf_amt;
    logic       shf_dir, shf_rotate;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [3:0] j_data [2];
    int         j_amt  [2];
    bit         j_dir  [2];
    bit         j_rot  [2];
    bit         rr_m;

    always #5 clk = ~clk;

    // External shifter: one pass of 0..3 positions
    function automatic logic [3:0] shifter(input logic [3:0] d, input int a, input bit dir, input bit rot);
        logic [7:0] dd;
        dd = {d, d};
        if (rot) begin
            if (dir) shifter = dd[7-a -: 4];
            else     shifter = dd[3+a -: 4];
        end else begin
            if (dir) shifter = 4'((int'(d) << a) & 15);
            else     shifter = 4'(int'(d) >> a);
        end
    endfunction

    // Whole-job reference result
    function automatic logic [3:0] ref_shift(input logic [3:0] d, input int amt, input bit dir, input bit rot);
        int v, k;
        v = int'(d);
        if (rot) begin
            k = amt % 4;
            if (dir) ref_shift = 4'(((v << k) | (v >> (4 - k))) & 15);
            else     ref_shift = 4'(((v >> k) | (v << (4 - k))) & 15);
        end else if (amt >= 4) begin
            ref_shift = 4'd0;
        end else begin
            if (dir) ref_shift = 4'((v << amt) & 15);
            else     ref_shift = 4'(v >> amt);
        end
    endfunction

    assign shf_data_out = shifter(shf_data_in, int'(shf_amt), shf_dir, shf_rotate);

    shift_job_sequencer #(.AMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt),
        .req0_dir(req0_dir), .req0_rotate(req0_rotate), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt),
        .req1_dir(req1_dir), .req1_rotate(req1_rotate), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
        .resp_ready(resp_ready), .busy(busy),
        .shf_data_in(shf_data_in), .shf_amt(shf_amt), .shf_dir(shf_dir),
        .shf_rotate(shf_rotate), .shf_data_out(shf_data_out)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else pass_cnt++;
    endtask

    // Both requesters must never be readied together
    always @(negedge clk) begin
        if (rst_n === 1'b1) check_val("ready_excl", {31'd0, req0_ready & req1_ready}, 32'd0);
    end

    task automatic drive_reqs(input bit v0, input bit v1);
        req0_valid = v0; req0_data = j_data[0]; req0_amt = 4'(j_amt[0]);
        req0_dir = j_dir[0]; req0_rotate = j_rot[0];
        req1_valid = v1; req1_data = j_data[1]; req1_amt = 4'(j_amt[1]);
        req1_dir = j_dir[1]; req1_rotate = j_rot[1];
    endtask

    task automatic scramble_reqs();
        req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
        req0_data = 4'($urandom); req0_amt = 4'($urandom);
        req0_dir = 1'($urandom); req0_rotate = 1'($urandom);
        req1_data = 4'($urandom); req1_amt = 4'($urandom);
        req1_dir = 1'($urandom); req1_rotate = 1'($urandom);
    endtask

    task automatic randomize_job(input int n);
        j_data[n] = 4'($urandom);
        j_amt[n]  = int'($urandom_range(0, 15));
        j_dir[n]  = 1'($urandom);
        j_rot[n]  = 1'($urandom);
    endtask

    // One transaction starting at a negedge in IDLE; bp = stalled DONE edges
    task automatic run_txn(input bit v0, input bit v1, input int bp);
        int g, rem, ch;
        logic [3:0] exp_d, cur;
        g = (v0 && v1) ? int'(rr_m) : (v1 ? 1 : 0);
        drive_reqs(v0, v1);
        resp_ready = 1'b1;
        #1;
        check_val("rdy0_idle", {31'd0, req0_ready}, {31'd0, g == 0});
        check_val("rdy1_idle", {31'd0, req1_ready}, {31'd0, g == 1});
        @(posedge clk);
        @(negedge clk);
        rr_m  = (g == 0);
        exp_d = ref_shift(j_data[g], j_amt[g], j_dir[g], j_rot[g]);
        cur   = j_data[g];
        rem   = j_amt[g];
        do begin
            scramble_reqs();
            #1;
            ch = (rem > 3) ? 3 : rem;
            check_val("shf_amt", {30'd0, shf_amt}, ch);
            check_val("shf_in", {28'd0, shf_data_in}, {28'd0, cur});
            check_val("busy_shift", {31'd0, busy}, 32'd1);
            check_val("rv_shift", {31'd0, resp_valid}, 32'd0);
            check_val("rdy_shift", {30'd0, req1_ready, req0_ready}, 32'd0);
            cur = shifter(cur, ch, j_dir[g], j_rot[g]);
            rem -= ch;
            @(negedge clk);
        end while (rem > 0);
        for (int b = 0; b <= bp; b++) begin
            resp_ready = (b == bp);
            scramble_reqs();
            #1;
            check_val("resp_valid", {31'd0, resp_valid}, 32'd1);
            check_val("resp_data", {28'd0, resp_data}, {28'd0, exp_d});
            check_val("resp_id", {31'd0, resp_id}, g);
            check_val("rdy_done", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
        end
        check_val("busy_after", {31'd0, busy}, 32'd0);
        check_val("rv_after", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        resp_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            j_data[n] = 4'd0; j_amt[n] = 0; j_dir[n] = 1'b0; j_rot[n] = 1'b0;
        end
        drive_reqs(1'b0, 1'b0);
        rr_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_rv", {31'd0, resp_valid}, 32'd0);
        check_val("rst_rdata", {28'd0, resp_data}, 32'd0);
        check_val("rst_rid", {31'd0, resp_id}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_shf_amt", {30'd0, shf_amt}, 32'd0);
        check_val("rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin under constant contention: ids 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            randomize_job(0);
            randomize_job(1);
            run_txn(1'b1, 1'b1, 0);
        end

        j_data[0] = 4'b1010; j_amt[0] = 5;  j_dir[0] = 1'b1; j_rot[0] = 1'b1;
        run_txn(1'b1, 1'b0, 0);
        j_data[1] = 4'b1001; j_amt[1] = 2;  j_dir[1] = 1'b0; j_rot[1] = 1'b0;
        run_txn(1'b0, 1'b1, 0);
        j_data[1] = 4'b1100; j_amt[1] = 0;  j_dir[1] = 1'b0; j_rot[1] = 1'b0;
        run_txn(1'b0, 1'b1, 0);
        j_data[0] = 4'b1111; j_amt[0] = 15; j_dir[0] = 1'b1; j_rot[0] = 1'b0;
        run_txn(1'b1, 1'b0, 0);
        j_data[1] = 4'b1001; j_amt[1] = 15; j_dir[1] = 1'b0; j_rot[1] = 1'b1;
        run_txn(1'b0, 1'b1, 5);

        // Reset during the second pass of an amt-9 job
        j_data[0] = 4'b0110; j_amt[0] = 9; j_dir[0] = 1'b1; j_rot[0] = 1'b1;
        drive_reqs(1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check_val("rst_job_p1", {30'd0, shf_amt}, 32'd3);
        @(negedge clk);
        check_val("rst_job_p2", {30'd0, shf_amt}, 32'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_m  = 1'b0;
        check_val("srst_busy", {31'd0, busy}, 32'd0);
        check_val("srst_rv", {31'd0, resp_valid}, 32'd0);
        check_val("srst_shf_amt", {30'd0, shf_amt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("srst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        randomize_job(0);
        randomize_job(1);
        run_txn(1'b1, 1'b1, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            randomize_job(0);
            randomize_job(1);
            run_txn(sel[0], sel[1], int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/shift_job_sequencer.md
# shift_job_sequencer

Multi-cycle controller for the shared 4-bit `barrel_shifter`, whose per-pass shift amount is 0–3. It accepts shift jobs of 0–15 positions from two requesters and arbitrates between them round-robin. Each job is executed as a sequence of passes through the external `barrel_shifter`, with at most 3 positions per pass. The result is returned over a valid/ready response channel tagged with the requester ID.

## Interface
Parameters:
- `AMT_W`, 4: width of the job shift amount; jobs cover 0..2^AMT_W−1 positions.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req0_valid` / `req1_valid` in 1: job offered by requester 0 / 1.
- `req0_data` / `req1_data` in 4: operand.
- `req0_amt` / `req1_amt` in AMT_W: total shift amount.
- `req0_dir` / `req1_dir` in 1: 0 = right, 1 = left.
- `req0_rotate` / `req1_rotate` in 1: 1 = rotate, 0 = logical with zero fill.
- `req0_ready` / `req1_ready` out 1: job accepted on the edge where valid & ready.
- `resp_valid` out 1: result available.
- `resp_data` out 4: shifted result.
- `resp_id` out 1: requester that issued the job.
- `resp_ready` in 1: consumer accepts the result.
- `busy` out 1: high in SHIFT or DONE.
- `shf_data_in` out 4: drives `barrel_shifter.data_in`.
- `shf_amt` out 2: drives `barrel_shifter.shift_amt`.
- `shf_dir` out 1: drives `barrel_shifter.dir`.
- `shf_rotate` out 1: drives `barrel_shifter.rotate`.
- `shf_data_out` in 4: `barrel_shifter.data_out`; combinational path through the shifter.

## Operation
State machine with three states: IDLE, SHIFT, DONE.

IDLE
- `grant` is combinational. If exactly one `reqN_valid` is high, that requester is granted. If both are high, the requester selected by the round-robin pointer `rr_ptr` is granted.
- `reqN_ready` = (state == IDLE) && grant == N. It is never high for both requesters.
- On accept, latch the job into internal registers:
  - `work` ← data
  - `remaining` ← amt
  - `dir` and `rotate` flags
  - `id` ← N
- On accept, set `rr_ptr` ← ~N and go to SHIFT.

SHIFT
- Each cycle: `chunk` = min(`remaining`, 3).
- Drive the shifter: `shf_data_in` = `work`, `shf_amt` = `chunk`, `shf_dir` = `dir`, `shf_rotate` = `rotate`.
- On the edge: `work` ← `shf_data_out`, `remaining` ← `remaining` − `chunk`.
- Leave for DONE on the edge where the new `remaining` is 0.
- An amount-0 job still takes exactly one SHIFT pass with `chunk` = 0, so the data passes through unchanged.
- Pass count = max(1, ceil(amt/3)).

DONE
- `resp_valid` = 1, `resp_data` = `work`, `resp_id` = `id`.
- On `resp_valid` & `resp_ready`, go to IDLE.

Shifter pins outside SHIFT: `shf_amt` = 0, `shf_data_in` = `work`, `shf_dir` = `dir`, `shf_rotate` = `rotate`.

Arithmetic follows from chunking:
- Logical shifts of 4 or more positions yield 0000.
- Rotates are effectively amt mod 4.

## Timing
- Reset values: `rr_ptr` = 0; `work`, `remaining`, `dir`, `rotate`, `id` = 0; state IDLE.
- Outputs under reset: `resp_valid` = 0, `resp_data` = 0000, `resp_id` = 0, `busy` = 0, `shf_amt` = 0. `reqN_ready` follows IDLE and the valids; when neither valid is high, both are 0.
- Latency: job accepted at edge E; SHIFT occupies cycles E+1..E+P; `resp_valid` rises after edge E+P.
- No back-to-back acceptance: after the response handshake edge, IDLE lasts at least one cycle before the next accept edge.
- Backpressure: while `resp_ready` = 0, `resp_valid`, `resp_data` and `resp_id` hold stable, and both `reqN_ready` = 0.
- Requesters must hold `reqN_*` stable while valid and not accepted. The sequencer samples them only on the accept edge, so later changes do not affect an in-flight job.
- Sync reset asserted in any state: on the next edge, return to IDLE with all registers at reset values. The in-flight job and any pending response are discarded, and no response is emitted.
- `rr_ptr` updates only on accept. A single requester that is always valid is served every job slot.

## Test plan
- Req0 rotate-left of 1010 by 5, `resp_ready` = 1 → two SHIFT passes with `shf_amt` 3 then 2. `resp_data` = 0101, `resp_id` = 0; `resp_valid` is high 2 cycles after the accept edge.
- Req1 logical-right of 1001 by 2 → `resp_data` = 0010 after one pass. Then req1 1100 by 0 → one pass with `shf_amt` = 0 and `resp_data` = 1100.
- Both requesters continuously valid from reset → grants and `resp_id` sequence 0, 1, 0, 1. `req0_ready` and `req1_ready` are never high together.
- Logical-left of 1111 by 15 → 5 passes (3,3,3,3,3), `resp_data` = 0000. Rotate-right of 1001 by 15 → `resp_data` = 0011.
- Hold `resp_ready` = 0 for 5 cycles in DONE → response stays stable and no requester is accepted. Raising `resp_ready` completes the handshake; the next accept occurs no earlier than one cycle later.
- Assert `rst_n` = 0 for one cycle during the second SHIFT pass of an amt-9 job → IDLE, `busy` = 0, no `resp_valid`. The next job completes normally.
